pkt_parity_unit: RTL and testbench

//  Streaming, parametrised successor to the 3-bit even/odd parity generators.

---
 rtl/parity_pkg.sv | 13 +
 rtl/parity_reduce.sv | 15 +
 rtl/pkt_parity_unit.sv | 101 ++++++++++
 tb/tb_pkt_parity_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the packet parity blocks: packet FSM states and
// parity-sense constants.
package parity_pkg;

  typedef enum logic {
    IDLE,  // no beat of the current packet taken yet
    ACCUM  // at least one non-last beat folded into the accumulator
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one beat to a single parity bit.
// Also used by the deframer.
module parity_reduce #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  // Even parity of the beat: 1 when an odd number of bits are set
  always_comb begin
    par = ^data;
  end

endmodule

// File: rtl/pkt_parity_unit.sv
// Streaming packet parity generator/checker.
// Folds the parity of every accepted beat into an accumulator, loads one
// result (parity + mismatch against the received parity bit) per packet into
// an output register and hands it off over a valid/ready interface.
// Optional feature: define PAR_ERR_CNT_EN to add the saturating err_cnt port.
module pkt_parity_unit
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = PAR_EVEN,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err
`ifdef PAR_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pkt_parity_unit: DATA_W and CNT_W must be at least 1");
  end

  state_t state_q;
  logic   acc_q;
  logic   beat_par;
  logic   acc_next;
  logic   res_par;
  logic   res_err;
  logic   in_fire;
  logic   load;

  parity_reduce #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .data (in_data),
    .par  (beat_par)
  );

  // Handshake and next accumulator / result values for the current beat.
  // Non-last beats never wait; only a last beat needs the output register free.
  always_comb begin
    in_ready = !rst && (!in_last || !out_valid || out_ready);
    in_fire  = in_valid && in_ready;
    load     = in_fire && in_last;
    // First beat of a packet starts from a clean accumulator
    acc_next = (state_q == IDLE) ? beat_par : (acc_q ^ beat_par);
    res_par  = acc_next ^ ODD;
    res_err  = res_par ^ in_par;
  end

  // Packet FSM, accumulator and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      out_valid <= 1'b0;
      out_par   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_fire) begin
        if (in_last) begin
          state_q   <= IDLE;
          acc_q     <= 1'b0;
          // A same-edge consume is overridden here, keeping out_valid high
          out_valid <= 1'b1;
          out_par   <= res_par;
          out_err   <= res_err;
        end else begin
          state_q <= ACCUM;
          acc_q   <= acc_next;
        end
      end
    end
  end

`ifdef PAR_ERR_CNT_EN
  // Saturating count of results loaded with a parity mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (load && res_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_parity_unit.sv
// Self-checking bench for pkt_parity_unit: an even and an odd instance share
// one input stream; a packet-level model predicts handshakes and results.
module tb_pkt_parity_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       out_ready;
  logic       rdy_e, rdy_o;
  logic       ov_e, ov_o;
  logic       par_e, par_o;
  logic       err_e, err_o;
`ifdef PAR_ERR_CNT_EN
  logic [1:0] cnt_e, cnt_o;
`endif

  always #5 clk = ~clk;

  pkt_parity_unit #(.DATA_W(8), .ODD(1'b0), .CNT_W(2)) u_even (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy_e),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .out_valid (ov_e),
    .out_ready (out_ready),
    .out_par   (par_e),
    .out_err   (err_e)
`ifdef PAR_ERR_CNT_EN
    ,
    .err_cnt   (cnt_e)
`endif
  );

  pkt_parity_unit #(.DATA_W(8), .ODD(1'b1), .CNT_W(2)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy_o),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .out_valid (ov_o),
    .out_ready (out_ready),
    .out_par   (par_o),
    .out_err   (err_o)
`ifdef PAR_ERR_CNT_EN
    ,
    .err_cnt   (cnt_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: beats of the open packet and the pending result
  logic [7:0] beats[$];
  bit         m_ov;
  bit         m_par_e, m_err_e, m_par_o, m_err_o;
  int         m_cnt_e, m_cnt_o;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_par;  // even-parity result
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !rst && (!in_last || !m_ov || out_ready);
  endfunction

  task automatic model_edge();
    bit acc;
    int ones;
    bit p;
    if (rst) begin
      beats.delete();
      m_ov = 0; m_par_e = 0; m_err_e = 0; m_par_o = 0; m_err_o = 0;
      m_cnt_e = 0; m_cnt_o = 0;
    end else begin
      acc = in_valid && m_ready();
      if (m_ov && out_ready) m_ov = 0;
      if (acc) begin
        beats.push_back(in_data);
        if (in_last) begin
          ones = 0;
          foreach (beats[i]) ones += $countones(beats[i]);
          p = (ones % 2) != 0;
          m_par_e = p;
          m_err_e = p ^ in_par;
          m_par_o = !p;
          m_err_o = !p ^ in_par;
          if (m_err_e && m_cnt_e < 3) m_cnt_e++;
          if (m_err_o && m_cnt_o < 3) m_cnt_o++;
          m_ov = 1;
          beats.delete();
        end
      end
    end
  endtask

  // One clock: compare everything on the falling edge, advance model on the rising edge
  task automatic step();
    @(negedge clk);
    chk("in_ready_e", rdy_e, m_ready());
    chk("in_ready_o", rdy_o, m_ready());
    chk("out_valid_e", ov_e, m_ov);
    chk("out_valid_o", ov_o, m_ov);
    chk("out_par_e", par_e, m_par_e);
    chk("out_err_e", err_e, m_err_e);
    chk("out_par_o", par_o, m_par_o);
    chk("out_err_o", err_o, m_err_o);
`ifdef PAR_ERR_CNT_EN
    chk("err_cnt_e", cnt_e, m_cnt_e);
    chk("err_cnt_o", cnt_o, m_cnt_o);
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic p);
    in_valid = 1; in_data = d; in_last = l; in_par = p;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_data = 8'hxx; in_last = 0; in_par = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    chk("rst_out_valid", ov_e, 1'b0);
    chk("rst_out_par", par_e, 1'b0);
    chk("rst_in_ready", rdy_e, 1'b0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", rdy_e, 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'h07, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0};

    rst = 1; in_valid = 0; in_data = 0; in_last = 0; in_par = 0; out_ready = 1;
    @(posedge clk); model_edge(); #1;
    do_reset();

    // Single-beat 0x07: result 1 clk after acceptance
    out_ready = 0;
    beat(8'h07, 1, 1);
    chk("t1_out_valid", ov_e, 1'b1);
    chk("t1_out_par", par_e, 1'b1);
    chk("t1_out_err", err_e, 1'b0);
    out_ready = 1;
    idle(1);

    // Two-beat packet on the odd instance
    do_reset();
    beat(8'h03, 0, 1);
    chk("t2_no_early_valid", ov_o, 1'b0);
    beat(8'h01, 1, 1);
    chk("t2_odd_par", par_o, 1'b0);
    chk("t2_odd_err", err_o, 1'b1);
`ifdef PAR_ERR_CNT_EN
    chk("t2_odd_cnt", cnt_o, 2'd1);
`endif
    idle(1);

    // Back-pressure on a last beat while a result is pending
    out_ready = 0;
    beat(8'h07, 1, 1);
    in_valid = 1; in_data = 8'h03; in_last = 1; in_par = 0;
    #1;
    chk("t3_blocked", rdy_e, 1'b0);
    step();
    step();
    chk("t3_hold_par", par_e, 1'b1);
    chk("t3_hold_valid", ov_e, 1'b1);
    out_ready = 1;
    #1;
    chk("t3_release", rdy_e, 1'b1);
    step();
    chk("t3_new_valid", ov_e, 1'b1);
    chk("t3_new_par", par_e, 1'b0);
    idle(1);

    // Back-to-back single-beat packets from the table
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].data, 1, vecs[i].par);
      chk("t4_valid", ov_e, 1'b1);
      chk("t4_par_e", par_e, vecs[i].exp_par);
      chk("t4_err_e", err_e, vecs[i].exp_err);
      chk("t4_par_o", par_o, !vecs[i].exp_par);
      chk("t4_err_o", err_o, !vecs[i].exp_err);
    end
    idle(1);

    // Reset mid-packet discards the partial accumulation
    beat(8'h01, 0, 0);
    beat(8'h03, 0, 0);
    rst = 1;
    idle(1);
    chk("t5_rst_valid", ov_e, 1'b0);
    rst = 0;
    beat(8'h01, 1, 1);
    chk("t5_par", par_e, 1'b1);
    chk("t5_err", err_e, 1'b0);
    idle(1);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) beat(8'h01, 1, 0);
    idle(1);
`ifdef PAR_ERR_CNT_EN
    chk("t6_sat_e", cnt_e, 2'd3);
    chk("t6_odd_cnt", cnt_o, 2'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom % 97) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      in_last   = ($urandom % 3) == 0;
      in_par    = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      step();
    end
    rst = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
